// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment driver for packed BCD words.
// A frame-synchronised shadow buffer keeps the shown value tear-free,
// leading zeros are optionally blanked and non-decimal nibbles render as a dash.
module bcd_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int                CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic              LZ_EN   = (LZ_BLANK != 0);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic             tick;
  logic             boundary;

  logic [15:0]      pending;
  logic             pend_v;
  logic [15:0]      shadow;

  logic [3:0]       nib_p0;
  logic             lz_p0;
  logic [3:0]       an_p0;
  logic [6:0]       seg_p0;

  logic [3:0]       an_p1;
  logic [6:0]       seg_p1;
  logic             frame_done_p1;

  // Active-low {g,f,e,d,c,b,a} pattern for one nibble; 10..15 show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  endfunction

  assign tick     = (div_cnt == CNT_MAX);
  assign boundary = tick && (idx == 2'd3);

  // Prescaler and digit index: each digit stays selected for REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Double buffer: loads park in pending, shadow only changes at a frame boundary.
  // A load landing exactly on the boundary bypasses pending and goes straight to shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      pend_v  <= 1'b0;
      shadow  <= '0;
    end else if (boundary) begin
      pend_v <= 1'b0;
      if (load) begin
        shadow <= bcd;
      end else if (pend_v) begin
        shadow <= pending;
      end
    end else if (load) begin
      pending <= bcd;
      pend_v  <= 1'b1;
    end
  end

  // Stage p0: pick the current digit, decide blanking and build the next an/seg.
  always_comb begin
    nib_p0 = shadow[3:0];
    lz_p0  = 1'b0;
    an_p0  = 4'b1110;
    case (idx)
      2'd0: begin
        nib_p0 = shadow[3:0];
        lz_p0  = 1'b0;
        an_p0  = 4'b1110;
      end
      2'd1: begin
        nib_p0 = shadow[7:4];
        lz_p0  = LZ_EN && (shadow[15:4] == 12'h000);
        an_p0  = 4'b1101;
      end
      2'd2: begin
        nib_p0 = shadow[11:8];
        lz_p0  = LZ_EN && (shadow[15:8] == 8'h00);
        an_p0  = 4'b1011;
      end
      default: begin
        nib_p0 = shadow[15:12];
        lz_p0  = LZ_EN && (shadow[15:12] == 4'h0);
        an_p0  = 4'b0111;
      end
    endcase
    seg_p0 = glyph(nib_p0);
    if (blank || lz_p0) begin
      an_p0  = 4'b1111;
      seg_p0 = 7'b1111111;
    end
  end

  // Stage p1: registered display outputs and the frame boundary pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_p1         <= 4'b1111;
      seg_p1        <= 7'b1111111;
      frame_done_p1 <= 1'b0;
    end else begin
      an_p1         <= an_p0;
      seg_p1        <= seg_p0;
      frame_done_p1 <= boundary;
    end
  end

  assign an         = an_p1;
  assign seg        = seg_p1;
  assign frame_done = frame_done_p1;
  assign dp         = 1'b1;

endmodule
